// File: rtl/taito_sj_rom_pkg.sv
// Shared definitions for the Taito System SJ ROM download path.
// Holds the eprom region map (base/size), the region and controller state
// enums, the mask of regions that must be complete before the core may run,
// and a helper that returns the byte size of a required region.
`timescale 1ns/1ps
package taito_sj_rom_pkg;

  localparam int NUM_REGIONS = 6;
  localparam int NUM_REQ     = 5;

  // Region bases in the ioctl byte address space.
  localparam logic [31:0] R0_BASE = 32'h0000_0000; // main program
  localparam logic [31:0] R1_BASE = 32'h0000_8000; // banked program
  localparam logic [31:0] R2_BASE = 32'h0001_0000; // graphics
  localparam logic [31:0] R3_BASE = 32'h0001_8000; // sound
  localparam logic [31:0] R4_BASE = 32'h0001_C000; // palette
  localparam logic [31:0] R5_BASE = 32'h0001_C100; // optional, unbounded

  // Bytes that must arrive before a region counts as loaded.
  localparam logic [15:0] R0_SIZE = 16'h8000;
  localparam logic [15:0] R1_SIZE = 16'h8000;
  localparam logic [15:0] R2_SIZE = 16'h8000;
  localparam logic [15:0] R3_SIZE = 16'h4000;
  localparam logic [15:0] R4_SIZE = 16'h0100;

  localparam logic [NUM_REQ-1:0] REQ_MASK = 5'h1F;

  typedef enum logic [2:0] {
    R0 = 3'd0,
    R1 = 3'd1,
    R2 = 3'd2,
    R3 = 3'd3,
    R4 = 3'd4,
    R5 = 3'd5
  } region_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    HOLD  = 3'd2,
    READY = 3'd3,
    FAULT = 3'd4
  } state_e;

  // Size of a required region; R5 has no size and never completes.
  function automatic logic [15:0] region_size(input int idx);
    case (idx)
      0:       return R0_SIZE;
      1:       return R1_SIZE;
      2:       return R2_SIZE;
      3:       return R3_SIZE;
      4:       return R4_SIZE;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational ioctl address -> eprom region decoder.
// Ports:
//   addr       in  ADDR_W  ioctl byte address
//   region_oh  out 6       one-hot region select, bit i = region Ri
//   region_idx out 3       region index (region_e)
// Anything at or above the R5 base lands in R5, including addresses with
// bits set above bit 16, so stray high addresses never alias into the
// required regions.
`timescale 1ns/1ps
module rom_region_decode
  import taito_sj_rom_pkg::*;
#(
  parameter int ADDR_W = 25
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [5:0]        region_oh,
  output region_e           region_idx
);

  localparam logic [ADDR_W-1:0] B1 = ADDR_W'(R1_BASE);
  localparam logic [ADDR_W-1:0] B2 = ADDR_W'(R2_BASE);
  localparam logic [ADDR_W-1:0] B3 = ADDR_W'(R3_BASE);
  localparam logic [ADDR_W-1:0] B4 = ADDR_W'(R4_BASE);
  localparam logic [ADDR_W-1:0] B5 = ADDR_W'(R5_BASE);

  always_comb begin
    region_idx = R0;
    if (addr >= B5)      region_idx = R5;
    else if (addr >= B4) region_idx = R4;
    else if (addr >= B3) region_idx = R3;
    else if (addr >= B2) region_idx = R2;
    else if (addr >= B1) region_idx = R1;
    region_oh = 6'b000001 << region_idx;
  end

endmodule

// File: rtl/rom_download_ctrl.sv
// ROM download sequencer for the Taito System SJ eprom regions.
// Registers every accepted ioctl byte towards the eproms with a one-hot
// region select, counts bytes per required region, keeps a mod-256 checksum
// and holds the core in reset until all required regions are loaded.
// Ports:
//   CLK, RST_N           clock (also eprom CLK_DL), async active-low reset
//   IOCTL_DOWNLOAD/INDEX download active flag and file index
//   IOCTL_WR/ADDR/DATA   byte strobe, byte address, byte data
//   ADDR_DL/DATA_DL      registered address/data to the eproms
//   WR_DL                one-cycle write pulse, one cycle after acceptance
//   CS_DL                one-hot region select, holds its last value
//   DONE_MASK            per required region: byte count reached size
//   CHECKSUM             mod-256 sum of accepted bytes
//   ROM_READY, LOAD_ERR  download outcome
//   CORE_RESET           active-high reset to CPUs and video
//   STATE_DBG            current controller state (state_e encoding)
//
// Handshake: the ioctl side has no back-pressure. A byte is taken exactly
// when IOCTL_WR is high together with IOCTL_DOWNLOAD, a matching index and
// the controller in LOAD; WR_DL is the matching single-cycle valid towards
// the eproms, which are always ready.
`timescale 1ns/1ps
module rom_download_ctrl
  import taito_sj_rom_pkg::*;
#(
  parameter int         ADDR_W      = 25,
  parameter int         HOLD_CYCLES = 16,
  parameter logic [7:0] ROM_INDEX   = 8'h00
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IOCTL_DOWNLOAD,
  input  logic [7:0]        IOCTL_INDEX,
  input  logic              IOCTL_WR,
  input  logic [ADDR_W-1:0] IOCTL_ADDR,
  input  logic [7:0]        IOCTL_DATA,
  output logic [ADDR_W-1:0] ADDR_DL,
  output logic [7:0]        DATA_DL,
  output logic              WR_DL,
  output logic [5:0]        CS_DL,
  output logic [4:0]        DONE_MASK,
  output logic [7:0]        CHECKSUM,
  output logic              ROM_READY,
  output logic              LOAD_ERR,
  output logic              CORE_RESET,
  output logic [2:0]        STATE_DBG
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  state_e               state, state_n;
  logic [7:0]           hold_cnt;
  logic [15:0]          region_cnt [NUM_REQ];
  logic [7:0]           checksum_q;
  logic [NUM_REQ-1:0]   done;
  logic                 start;
  logic                 accept;
  logic                 enter_load;
  logic [5:0]           region_oh;
  region_e              region_idx;

  rom_region_decode #(.ADDR_W(ADDR_W)) u_decode (
    .addr       (IOCTL_ADDR),
    .region_oh  (region_oh),
    .region_idx (region_idx)
  );

  assign start  = IOCTL_DOWNLOAD && (IOCTL_INDEX == ROM_INDEX);
  assign accept = (state == LOAD) && IOCTL_WR && start;

  always_comb begin
    done = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      done[i] = (region_cnt[i] == region_size(i));
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, READY, FAULT: if (start) state_n = LOAD;
      LOAD:               if (!IOCTL_DOWNLOAD) state_n = HOLD;
      // A new download request during HOLD is not looked at until the
      // hold window has run out.
      HOLD: if (hold_cnt == 8'd0) state_n = (done == REQ_MASK) ? READY : FAULT;
      default:            state_n = IDLE;
    endcase
  end

  // Every entry into LOAD starts a fresh image: counts and checksum clear.
  assign enter_load = (state != LOAD) && (state_n == LOAD);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_cnt <= '0;
    end else if (state == LOAD && state_n == HOLD) begin
      hold_cnt <= HOLD_INIT;
    end else if (state == HOLD && hold_cnt != 8'd0) begin
      hold_cnt <= hold_cnt - 8'd1;
    end
  end

  // ---------------- counters / checksum ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REQ; i++) region_cnt[i] <= '0;
      checksum_q <= '0;
    end else if (enter_load) begin
      for (int i = 0; i < NUM_REQ; i++) region_cnt[i] <= '0;
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + IOCTL_DATA;
      // Duplicate addresses count again; only saturation stops a counter.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (int'(region_idx) == i && !done[i]) begin
          region_cnt[i] <= region_cnt[i] + 16'd1;
        end
      end
    end
  end

  // ---------------- eprom write pipeline ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ADDR_DL <= '0;
      DATA_DL <= '0;
      WR_DL   <= 1'b0;
      CS_DL   <= '0;
    end else begin
      WR_DL <= accept;
      if (accept) begin
        ADDR_DL <= IOCTL_ADDR;
        DATA_DL <= IOCTL_DATA;
        CS_DL   <= region_oh;
      end
    end
  end

  // ---------------- status outputs ----------------
  assign DONE_MASK  = done;
  assign CHECKSUM   = checksum_q;
  assign ROM_READY  = (state == READY);
  assign LOAD_ERR   = (state == FAULT);
  // Combinational term on start so the core is back in reset in the very
  // cycle a reload is requested, before LOAD is entered.
  assign CORE_RESET = (state != READY) || start;
  assign STATE_DBG  = state;

endmodule

// File: tb/tb_rom_download_ctrl.sv
`timescale 1ns/1ps
module tb_rom_download_ctrl;

  localparam int AW   = 25;
  localparam int HOLD = 16;

  // ---------------- clock / reset ----------------
  logic          CLK = 1'b0;
  logic          RST_N;
  logic          IOCTL_DOWNLOAD;
  logic [7:0]    IOCTL_INDEX;
  logic          IOCTL_WR;
  logic [AW-1:0] IOCTL_ADDR;
  logic [7:0]    IOCTL_DATA;
  logic [AW-1:0] ADDR_DL;
  logic [7:0]    DATA_DL;
  logic          WR_DL;
  logic [5:0]    CS_DL;
  logic [4:0]    DONE_MASK;
  logic [7:0]    CHECKSUM;
  logic          ROM_READY;
  logic          LOAD_ERR;
  logic          CORE_RESET;
  logic [2:0]    STATE_DBG;

  always #5 CLK = ~CLK;

  rom_download_ctrl #(.ADDR_W(AW), .HOLD_CYCLES(HOLD), .ROM_INDEX(8'h00)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .IOCTL_DOWNLOAD (IOCTL_DOWNLOAD),
    .IOCTL_INDEX    (IOCTL_INDEX),
    .IOCTL_WR       (IOCTL_WR),
    .IOCTL_ADDR     (IOCTL_ADDR),
    .IOCTL_DATA     (IOCTL_DATA),
    .ADDR_DL        (ADDR_DL),
    .DATA_DL        (DATA_DL),
    .WR_DL          (WR_DL),
    .CS_DL          (CS_DL),
    .DONE_MASK      (DONE_MASK),
    .CHECKSUM       (CHECKSUM),
    .ROM_READY      (ROM_READY),
    .LOAD_ERR       (LOAD_ERR),
    .CORE_RESET     (CORE_RESET),
    .STATE_DBG      (STATE_DBG)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  int         m_cnt  [5];
  int         m_size [5] = '{32768, 32768, 32768, 16384, 256};
  logic [7:0] m_chk;
  logic [5:0] m_cs;

  function automatic int region_of(input logic [AW-1:0] a);
    if (a >= 25'h1C100) return 5;
    if (a >= 25'h1C000) return 4;
    if (a >= 25'h18000) return 3;
    if (a >= 25'h10000) return 2;
    if (a >= 25'h08000) return 1;
    return 0;
  endfunction

  function automatic logic [4:0] model_done();
    logic [4:0] d;
    for (int i = 0; i < 5; i++) d[i] = (m_cnt[i] == m_size[i]);
    return d;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    m_chk = 8'h00;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_download(input logic [7:0] idx);
    IOCTL_INDEX    = idx;
    IOCTL_DOWNLOAD = 1'b1;
    tick();
    model_clear();
  endtask

  // One accepted byte; the registered outputs are checked one cycle later.
  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
    int r;
    IOCTL_WR   = 1'b1;
    IOCTL_ADDR = a;
    IOCTL_DATA = d;
    tick();
    IOCTL_WR = 1'b0;
    r = region_of(a);
    if (r < 5 && m_cnt[r] < m_size[r]) m_cnt[r]++;
    m_chk = m_chk + d;
    m_cs  = 6'(1) << r;
    tests_run++;
    if (WR_DL !== 1'b1 || ADDR_DL !== a || DATA_DL !== d || CS_DL !== m_cs) begin
      tests_failed++;
      $display("FAIL write_pipe a=%h: got wr=%b addr=%h data=%h cs=%b, expected wr=1 addr=%h data=%h cs=%b",
               a, WR_DL, ADDR_DL, DATA_DL, CS_DL, a, d, m_cs);
    end
  endtask

  task automatic idle_cycle();
    tick();
    tests_run++;
    if (WR_DL !== 1'b0 || CS_DL !== m_cs) begin
      tests_failed++;
      $display("FAIL idle_hold: got wr=%b cs=%b, expected wr=0 cs=%b", WR_DL, CS_DL, m_cs);
    end
  endtask

  // Counts clock edges until ROM_READY or LOAD_ERR rises (0 = never).
  task automatic wait_outcome(input int already, output int n);
    n = 0;
    for (int k = already + 1; k <= HOLD + 8; k++) begin
      tick();
      if (ROM_READY === 1'b1 || LOAD_ERR === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0; IOCTL_DOWNLOAD = 1'b0; IOCTL_INDEX = 8'h00;
    IOCTL_WR = 1'b0; IOCTL_ADDR = '0; IOCTL_DATA = 8'h00;
    model_clear();
    m_cs = 6'h00;
    repeat (2) @(posedge CLK);
    #1;
    tests_run++;
    if ({ADDR_DL, DATA_DL, WR_DL, CS_DL, DONE_MASK, CHECKSUM, ROM_READY, LOAD_ERR, CORE_RESET}
        !== {25'h0, 8'h00, 1'b0, 6'h00, 5'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_values: got addr=%h data=%h wr=%b cs=%b done=%h chk=%h rdy=%b err=%b crst=%b, expected all 0 and crst=1",
               ADDR_DL, DATA_DL, WR_DL, CS_DL, DONE_MASK, CHECKSUM, ROM_READY, LOAD_ERR, CORE_RESET);
    end
    @(negedge CLK) RST_N = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_load();
    start_download(8'h00);
    for (int a = 0; a < 'h4000; a++) do_write(AW'(a), 8'($urandom));
    tests_run++;
    if (CHECKSUM !== m_chk) begin
      tests_failed++;
      $display("FAIL midload_checksum: got %h expected %h", CHECKSUM, m_chk);
    end
    #2;
    RST_N = 1'b0;
    IOCTL_DOWNLOAD = 1'b0;
    #1;
    tests_run++;
    if ({ADDR_DL, DATA_DL, WR_DL, CS_DL, DONE_MASK, CHECKSUM, ROM_READY, LOAD_ERR, CORE_RESET}
        !== {25'h0, 8'h00, 1'b0, 6'h00, 5'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL midload_async_reset: got addr=%h data=%h wr=%b cs=%b done=%h chk=%h rdy=%b err=%b crst=%b, expected all 0 and crst=1",
               ADDR_DL, DATA_DL, WR_DL, CS_DL, DONE_MASK, CHECKSUM, ROM_READY, LOAD_ERR, CORE_RESET);
    end
    model_clear();
    m_cs = 6'h00;
    @(negedge CLK) RST_N = 1'b1;
    tick();
  endtask

  task automatic test_full_load();
    int n;
    start_download(8'h00);
    for (int a = 0; a < 'h1C100; a++) do_write(AW'(a), 8'(a));
    IOCTL_DOWNLOAD = 1'b0;
    wait_outcome(0, n);
    tests_run++;
    if (n !== HOLD + 1 || ROM_READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_ready_timing: got ready after %0d cycles (rdy=%b), expected %0d", n, ROM_READY, HOLD + 1);
    end
    tests_run++;
    if (DONE_MASK !== 5'h1F || CHECKSUM !== m_chk || CHECKSUM !== 8'h80) begin
      tests_failed++;
      $display("FAIL full_status: got done=%h chk=%h, expected done=1f chk=%h", DONE_MASK, CHECKSUM, m_chk);
    end
    tests_run++;
    if (CORE_RESET !== 1'b0 || LOAD_ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_core_reset: got crst=%b err=%b, expected crst=0 err=0", CORE_RESET, LOAD_ERR);
    end
  endtask

  task automatic test_index_filter();
    IOCTL_INDEX    = 8'h01;
    IOCTL_DOWNLOAD = 1'b1;
    for (int k = 0; k < 100; k++) begin
      IOCTL_WR   = 1'b1;
      IOCTL_ADDR = AW'($urandom);
      IOCTL_DATA = 8'($urandom);
      tick();
      tests_run++;
      if (WR_DL !== 1'b0 || CORE_RESET !== 1'b0 || ROM_READY !== 1'b1) begin
        tests_failed++;
        $display("FAIL index_filter k=%0d: got wr=%b crst=%b rdy=%b, expected wr=0 crst=0 rdy=1", k, WR_DL, CORE_RESET, ROM_READY);
      end
    end
    IOCTL_WR = 1'b0;
    IOCTL_DOWNLOAD = 1'b0;
    tick();
    tests_run++;
    if (ROM_READY !== 1'b1 || CHECKSUM !== m_chk || DONE_MASK !== 5'h1F) begin
      tests_failed++;
      $display("FAIL index_filter_after: got rdy=%b chk=%h done=%h, expected rdy=1 chk=%h done=1f", ROM_READY, CHECKSUM, DONE_MASK, m_chk);
    end
  endtask

  task automatic test_reload();
    tests_run++;
    if (CORE_RESET !== 1'b0) begin
      tests_failed++;
      $display("FAIL reload_before: got crst=%b expected 0", CORE_RESET);
    end
    IOCTL_INDEX    = 8'h00;
    IOCTL_DOWNLOAD = 1'b1;
    #1;
    tests_run++;
    if (CORE_RESET !== 1'b1) begin
      tests_failed++;
      $display("FAIL reload_same_cycle: got crst=%b expected 1", CORE_RESET);
    end
    tick();
    model_clear();
    tests_run++;
    if (DONE_MASK !== 5'h00 || CHECKSUM !== 8'h00 || ROM_READY !== 1'b0 || CORE_RESET !== 1'b1) begin
      tests_failed++;
      $display("FAIL reload_cleared: got done=%h chk=%h rdy=%b crst=%b, expected done=0 chk=0 rdy=0 crst=1",
               DONE_MASK, CHECKSUM, ROM_READY, CORE_RESET);
    end
  endtask

  task automatic test_edge_timing();
    int n;
    logic [7:0] held_data;
    do_write(25'h1C100, 8'hA5);
    tests_run++;
    if (CS_DL !== 6'b100000 || ADDR_DL !== 25'h1C100 || DATA_DL !== 8'hA5) begin
      tests_failed++;
      $display("FAIL edge_r5_write: got cs=%b addr=%h data=%h, expected cs=100000 addr=1c100 data=a5", CS_DL, ADDR_DL, DATA_DL);
    end
    do_write(25'h1000005, 8'($urandom));   // high address bit set: R5
    do_write(25'h1C0FF, 8'($urandom));     // last palette byte: R4
    held_data = DATA_DL;
    // IOCTL_WR coincident with the download falling.
    IOCTL_WR = 1'b1; IOCTL_ADDR = 25'h10; IOCTL_DATA = ~held_data;
    IOCTL_DOWNLOAD = 1'b0;
    tick();
    IOCTL_WR = 1'b0;
    n = 1;
    tests_run++;
    if (WR_DL !== 1'b0 || DATA_DL !== held_data || CS_DL !== m_cs) begin
      tests_failed++;
      $display("FAIL edge_fall_write: got wr=%b data=%h cs=%b, expected wr=0 data=%h cs=%b", WR_DL, DATA_DL, CS_DL, held_data, m_cs);
    end
    // Download request and writes during HOLD are ignored.
    for (int k = 2; k <= 5; k++) begin
      IOCTL_DOWNLOAD = 1'b1; IOCTL_WR = 1'b1;
      IOCTL_ADDR = AW'($urandom_range(0, 'h1FFFF)); IOCTL_DATA = 8'($urandom);
      tick();
      n = k;
      tests_run++;
      if (WR_DL !== 1'b0 || CORE_RESET !== 1'b1 || ROM_READY !== 1'b0 || LOAD_ERR !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_ignores_start k=%0d: got wr=%b crst=%b rdy=%b err=%b, expected wr=0 crst=1 rdy=0 err=0",
                 k, WR_DL, CORE_RESET, ROM_READY, LOAD_ERR);
      end
    end
    IOCTL_DOWNLOAD = 1'b0; IOCTL_WR = 1'b0;
    wait_outcome(n, n);
    tests_run++;
    if (n !== HOLD + 1 || LOAD_ERR !== 1'b1) begin
      tests_failed++;
      $display("FAIL edge_fault_timing: got err after %0d cycles (err=%b), expected %0d", n, LOAD_ERR, HOLD + 1);
    end
    tests_run++;
    if (DONE_MASK !== model_done() || CHECKSUM !== m_chk || ROM_READY !== 1'b0 || CORE_RESET !== 1'b1) begin
      tests_failed++;
      $display("FAIL edge_fault_status: got done=%h chk=%h rdy=%b crst=%b, expected done=%h chk=%h rdy=0 crst=1",
               DONE_MASK, CHECKSUM, ROM_READY, CORE_RESET, model_done(), m_chk);
    end
  endtask

  task automatic test_random_loads();
    int n;
    int nw;
    logic [AW-1:0] a;
    logic exp_ready;
    for (int it = 0; it < 3; it++) begin
      start_download(8'h00);
      nw = (it == 0) ? 256 + $urandom_range(0, 20) : $urandom_range(40, 200);
      for (int k = 0; k < nw; k++) begin
        if (it != 0 && $urandom_range(0, 4) == 0) idle_cycle();
        if (it == 0 || $urandom_range(0, 1) == 1) a = 25'h1C000 + AW'($urandom_range(0, 255));
        else a = AW'($urandom);
        do_write(a, 8'($urandom));
      end
      IOCTL_DOWNLOAD = 1'b0;
      wait_outcome(0, n);
      exp_ready = (model_done() == 5'h1F);
      tests_run++;
      if (n !== HOLD + 1) begin
        tests_failed++;
        $display("FAIL rand_outcome_timing it=%0d: got %0d cycles, expected %0d", it, n, HOLD + 1);
      end
      tests_run++;
      if (DONE_MASK !== model_done() || CHECKSUM !== m_chk || ROM_READY !== exp_ready ||
          LOAD_ERR !== !exp_ready || CORE_RESET !== !exp_ready) begin
        tests_failed++;
        $display("FAIL rand_status it=%0d: got done=%h chk=%h rdy=%b err=%b crst=%b, expected done=%h chk=%h rdy=%b err=%b crst=%b",
                 it, DONE_MASK, CHECKSUM, ROM_READY, LOAD_ERR, CORE_RESET,
                 model_done(), m_chk, exp_ready, !exp_ready, !exp_ready);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_reset_mid_load();
    test_full_load();
    test_index_filter();
    test_reload();
    test_edge_timing();
    test_random_loads();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rom_download_ctrl.md
Name: rom_download_ctrl

Overview:
- Sequences the ioctl ROM download into the Taito System SJ eprom regions.
- Registers each download byte and decodes it into a one-hot region strobe that drives the eprom_* CS_DL/WR inputs.
- Counts bytes per region, keeps a running checksum, and holds the core in reset until every required region is complete.
- Sits between the MiSTer ioctl interface and the eprom/cprom instances; it replaces the purely combinational address selection.

Parameters:
- ADDR_W, 25, ioctl address width.
- HOLD_CYCLES, 16, cycles CORE_RESET stays asserted after download ends (1..255).
- ROM_INDEX, 8'h00, ioctl index treated as ROM download; other indices are ignored.

Ports:
- CLK  in  1  system clock; also the download clock (CLK_DL of the eproms).
- RST_N  in  1  asynchronous active-low reset.
- IOCTL_DOWNLOAD  in  1  download in progress.
- IOCTL_INDEX  in  8  download file index.
- IOCTL_WR  in  1  byte-valid strobe, one cycle per byte.
- IOCTL_ADDR  in  ADDR_W  byte address.
- IOCTL_DATA  in  8  byte data.
- ADDR_DL  out  ADDR_W  registered address to the eproms.
- DATA_DL  out  8  registered data to the eproms.
- WR_DL  out  1  registered write strobe.
- CS_DL  out  6  registered one-hot region select, bits R0..R5.
- DONE_MASK  out  5  per required region: byte count reached region size.
- CHECKSUM  out  8  mod-256 sum of all accepted bytes.
- ROM_READY  out  1  all required regions loaded.
- LOAD_ERR  out  1  download ended with an incomplete region.
- CORE_RESET  out  1  active-high reset to the CPUs and video.

Behaviour:
- Region map, base/size:
  - R0 0x00000/0x8000 (main program)
  - R1 0x08000/0x8000 (banked program)
  - R2 0x10000/0x8000 (graphics)
  - R3 0x18000/0x4000 (sound)
  - R4 0x1C000/0x0100 (palette)
  - R5 at or above 0x1C100 (optional; counted in checksum only, never required)
- Reset values: ADDR_DL=0, DATA_DL=0, WR_DL=0, CS_DL=0, DONE_MASK=0, CHECKSUM=0, ROM_READY=0, LOAD_ERR=0, CORE_RESET=1. State IDLE, all counters 0.
- Byte acceptance: a byte is accepted when IOCTL_WR & IOCTL_DOWNLOAD & (IOCTL_INDEX==ROM_INDEX) and state is LOAD.
- Accept pipeline, latency 1: on the cycle after acceptance, WR_DL=1 and ADDR_DL/DATA_DL/CS_DL reflect the accepted byte. WR_DL is a single-cycle pulse; CS_DL holds its last value otherwise.
- Per-region counters (16 bit) increment on acceptance and saturate at region size. DONE_MASK[i] is set when counter i equals size i.
- CHECKSUM += data on each acceptance, wrapping mod 256.
- States:
  - IDLE: CORE_RESET=1. Download start with matching index -> LOAD.
  - LOAD: entered with counters, DONE_MASK, CHECKSUM, LOAD_ERR and ROM_READY all cleared. CORE_RESET=1. Accepts bytes. IOCTL_DOWNLOAD low -> HOLD, hold counter loaded with HOLD_CYCLES-1.
  - HOLD: CORE_RESET=1; decrement hold counter. At 0: DONE_MASK==5'h1F -> READY, else -> FAULT.
  - READY: ROM_READY=1, CORE_RESET=0.
  - FAULT: LOAD_ERR=1, CORE_RESET=1.
  - From READY or FAULT, download start with matching index -> LOAD. CORE_RESET rises in the same cycle the transition is taken.
- Boundaries:
  - IOCTL_WR on the same cycle IOCTL_DOWNLOAD falls: not accepted (download already low).
  - Non-matching index: no strobes, state unchanged; READY persists.
  - Download rising while in HOLD: ignored until HOLD completes.
  - Duplicate addresses count again (counter saturation only).
  - Addresses at or above 0x1C100 select R5 even if ADDR_W bits beyond 17 are set.
  - RST_N low mid-load: immediate return to reset values; the partially written RAM contents are not cleared.

Decomposition:
- Package taito_sj_rom_pkg holds:
  - region base/size localparams
  - region enum (R0..R5)
  - state typedef (IDLE, LOAD, HOLD, READY, FAULT)
  - REQ_MASK = 5'h1F
- One sub-module: rom_region_decode, combinational address -> one-hot 6-bit region plus region index.

Test Plan:
- Full load: download index 0, bytes 0x00000..0x1C0FF, data=addr[7:0] -> CS_DL one-hot per region, DONE_MASK=5'h1F, CHECKSUM=0x80, ROM_READY=1 and CORE_RESET=0 exactly HOLD_CYCLES+1 cycles after download falls.
- Short load: stop at 0x1BFFF -> DONE_MASK=5'h0F, LOAD_ERR=1, CORE_RESET stays 1, ROM_READY=0.
- Index filter: from READY, download index 1 with 100 writes -> WR_DL never pulses, READY retained, CHECKSUM unchanged.
- Reload: from READY, start index-0 download -> CORE_RESET=1 same cycle, DONE_MASK=0 and CHECKSUM=0 next cycle.
- Edge timing: write 0xA5 at 0x1C100 -> one cycle later WR_DL=1, CS_DL=6'b100000, ADDR_DL=0x1C100. IOCTL_WR coincident with download fall -> no WR_DL.
- Reset mid-load: RST_N low after 0x4000 bytes -> all outputs return to reset values asynchronously; a following full load reaches READY.
